// File: rtl/prog_loader_arbiter.sv
// RAM write-port arbiter between the CPU and a host byte-stream loader.
// Halts the CPU, streams bytes to RAM from address 0, then resets and releases the CPU.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   prog_mode                 host programming-session request (level)
//   host_valid/data/last      host byte stream, host_ready = byte accepted
//   cpu_addr/wdata/we         CPU-side RAM request (MAR, bus, decoder ri)
//   cpu_hlt                   CPU halted acknowledge
//   cpu_halt_req, cpu_rst_n   CPU halt request, active-low CPU reset
//   cpu_grant                 1 while the CPU owns the RAM port
//   ram_addr/wdata/we         RAM write/address port
//   load_count                bytes written in the last/current session
//   done, err_abort           normal-finish pulse, sticky abort flag
module prog_loader_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int SETTLE     = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_hlt,
  output logic              cpu_halt_req,
  output logic              cpu_rst_n,
  output logic              cpu_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W:0]   load_count,
  output logic              done,
  output logic              err_abort
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_RUN,
    S_WAIT_HALT,
    S_LOAD_IDLE,
    S_LOAD_SETUP,
    S_LOAD_WRITE,
    S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [SCW-1:0]    r_settle;
  logic [RCW-1:0]    r_rst_cnt;
  logic              r_cpu_rst_n;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_err;
  logic              w_wr_end;
  logic              w_enter_rel;

  // A write ends the session on the tagged last byte, on the top
  // address (the pointer must never wrap), or when the host has
  // abandoned the session.
  assign w_wr_end    = r_last | (&r_ptr) | r_err | ~prog_mode;
  assign w_enter_rel = (w_next == S_RELEASE) && (r_state != S_RELEASE);

  always_comb begin
    w_next       = r_state;
    host_ready   = 1'b0;
    cpu_grant    = 1'b0;
    cpu_halt_req = 1'b1;
    ram_addr     = r_ptr;
    ram_wdata    = r_data;
    ram_we       = 1'b0;
    unique case (r_state)
      S_RUN: begin
        cpu_grant    = 1'b1;
        cpu_halt_req = 1'b0;
        ram_addr     = cpu_addr;
        ram_wdata    = cpu_wdata;
        ram_we       = cpu_we;
        if (prog_mode) w_next = S_WAIT_HALT;
      end
      S_WAIT_HALT: begin
        if (!prog_mode)   w_next = S_RUN;
        else if (cpu_hlt) w_next = S_LOAD_IDLE;
      end
      S_LOAD_IDLE: begin
        host_ready = 1'b1;
        if (host_valid)     w_next = S_LOAD_SETUP;
        else if (!prog_mode) w_next = S_RELEASE;
      end
      S_LOAD_SETUP: begin
        if (r_settle == '0) w_next = S_LOAD_WRITE;
      end
      S_LOAD_WRITE: begin
        // A reset arriving in the write cycle drops the write.
        ram_we = ~rst;
        w_next = w_wr_end ? S_RELEASE : S_LOAD_IDLE;
      end
      S_RELEASE: begin
        if (r_cpu_rst_n && !prog_mode) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_ptr       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_settle    <= '0;
      r_rst_cnt   <= '0;
      r_cpu_rst_n <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      unique case (r_state)
        S_RUN: r_cpu_rst_n <= 1'b1;
        S_WAIT_HALT: begin
          if (w_next == S_LOAD_IDLE) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD_IDLE: begin
          if (w_next == S_LOAD_SETUP) begin
            r_data   <= host_data;
            r_last   <= host_last;
            r_settle <= SCW'(SETTLE - 1);
          end else if (w_next == S_RELEASE) begin
            r_err <= 1'b1;
          end
        end
        S_LOAD_SETUP: begin
          if (!prog_mode) r_err <= 1'b1;
          if (r_settle != '0) r_settle <= r_settle - SCW'(1);
        end
        S_LOAD_WRITE: begin
          r_count <= r_count + (ADDR_W+1)'(1);
          if (!prog_mode) r_err <= 1'b1;
          if (w_next == S_LOAD_IDLE) r_ptr <= r_ptr + ADDR_W'(1);
        end
        S_RELEASE: begin
          if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RCW'(1);
          else                 r_cpu_rst_n <= 1'b1;
          if (w_next == S_RUN) r_done <= ~r_err;
        end
        default: ;
      endcase
      // Entering RELEASE starts the CPU reset window.
      if (w_enter_rel) begin
        r_cpu_rst_n <= 1'b0;
        r_rst_cnt   <= RCW'(RST_CYCLES - 1);
      end
    end
  end

  assign cpu_rst_n  = r_cpu_rst_n;
  assign load_count = r_count;
  assign done       = r_done;
  assign err_abort  = r_err;

endmodule
